rns_add_arbiter: RTL and testbench

- Two-requester arbiter and two-stage pipeline around a shared full-polynomial RNS modular add/subtract datapath.
- Lets the key-switch/rescale engines and the ciphertext-add path time-share one N_SLOTS x q_BASIS_LEN adder array instead of each instantiating its own.
- Each accepted request yields exactly one tagged result, in acceptance order, under valid/ready backpressure.

---
 rtl/rns_add_arbiter_pkg.sv | 48 ++++
 rtl/rns_add_arbiter_modred.sv | 29 ++
 rtl/rns_add_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rns_add_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rns_add_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rns_add_arbiter_pkg
// Shared RNS definitions for the time-shared modular add/subtract datapath.
//   N_SLOTS      : number of polynomial coefficient slots
//   q_BASIS_LEN  : number of RNS residues per slot
//   q_BITS       : residue width in bits
//   q_BASIS[]    : per-residue moduli (all < 2^q_BITS)
//   q_BASIS_poly      : full polynomial, q_BITS per residue
//   q_BASIS_wide_poly : unreduced polynomial, q_BITS+1 per residue
//   raw_addsub()      : unreduced a+b or a+(q-b) for one residue
// ----------------------------------------------------------------------------
package rns_add_arbiter_pkg;

    localparam int unsigned N_SLOTS     = 4;
    localparam int unsigned q_BASIS_LEN = 3;
    localparam int unsigned q_BITS      = 8;

    typedef logic [q_BITS-1:0] residue_t;
    typedef logic [q_BITS:0]   wide_residue_t;

    typedef residue_t      [N_SLOTS-1:0][q_BASIS_LEN-1:0] q_BASIS_poly;
    typedef wide_residue_t [N_SLOTS-1:0][q_BASIS_LEN-1:0] q_BASIS_wide_poly;

    localparam residue_t q_BASIS [q_BASIS_LEN] = '{
        residue_t'(251),
        residue_t'(241),
        residue_t'(193)
    };

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    // Subtraction is folded into an addition of the additive inverse (q - b),
    // so both operations share the same conditional-subtract reduction.
    function automatic wide_residue_t raw_addsub(
        input residue_t a,
        input residue_t b,
        input logic     sub,
        input residue_t q
    );
        residue_t b_eff;
        b_eff = sub ? residue_t'(q - b) : b;
        return {1'b0, a} + {1'b0, b_eff};
    endfunction

endpackage

// File: rtl/rns_add_arbiter_modred.sv
// ----------------------------------------------------------------------------
// rns_modred_stage
// Combinational per-residue modular reduction of an unreduced sum in [0, 2q):
// subtracts q when the value is >= q.
//   raw_i : unreduced polynomial (q_BITS+1 per residue)
//   red_o : reduced polynomial, each residue in [0, q_BASIS[j])
// ----------------------------------------------------------------------------
module rns_modred_stage
    import rns_add_arbiter_pkg::*;
(
    input  q_BASIS_wide_poly raw_i,
    output q_BASIS_poly      red_o
);

    always_comb begin
        red_o = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            for (int unsigned j = 0; j < q_BASIS_LEN; j++) begin
                // >= so that a sum landing exactly on q wraps to 0
                if (raw_i[i][j] >= {1'b0, q_BASIS[j]}) begin
                    red_o[i][j] = residue_t'(raw_i[i][j] - {1'b0, q_BASIS[j]});
                end else begin
                    red_o[i][j] = raw_i[i][j][q_BITS-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/rns_add_arbiter.sv
// ----------------------------------------------------------------------------
// rns_add_arbiter
// Two-requester arbiter in front of a shared two-stage RNS modular add/sub
// pipeline. Each accepted request yields one tagged result, in acceptance
// order, under valid/ready backpressure.
//   clk, rst_n             : clock, synchronous active-low reset
//   reqN_valid/reqN_ready  : request handshake (ready is combinational)
//   reqN_a, reqN_b         : operand polynomials (residues < q_BASIS[j])
//   reqN_sub               : 0 = A+B, 1 = A-B
//   out_valid/out_ready    : result handshake
//   out_data, out_id       : reduced result and issuing requester
//   ops_done               : results handed off, wraps modulo 2^CNT_W
// Parameters:
//   CNT_W : width of ops_done
//   RR_EN : 1 = round-robin, 0 = fixed priority (requester 0 highest)
// ----------------------------------------------------------------------------
module rns_add_arbiter
    import rns_add_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter bit          RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  q_BASIS_poly      req0_a,
    input  q_BASIS_poly      req0_b,
    input  logic             req0_sub,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  q_BASIS_poly      req1_a,
    input  q_BASIS_poly      req1_b,
    input  logic             req1_sub,

    output logic             out_valid,
    input  logic             out_ready,
    output q_BASIS_poly      out_data,
    output logic             out_id,
    output logic [CNT_W-1:0] ops_done
);

    // Stage 1: unreduced result
    logic             s1_valid_q, s1_valid_d;
    q_BASIS_wide_poly s1_raw_q,   s1_raw_d;
    logic             s1_id_q,    s1_id_d;

    // Stage 2: reduced result, drives the output port directly
    logic             s2_valid_q, s2_valid_d;
    q_BASIS_poly      s2_data_q,  s2_data_d;
    logic             s2_id_q,    s2_id_d;

    req_id_e          rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0] ops_q,      ops_d;

    logic             s1_adv, s2_adv;
    logic             pick0, pick1;
    logic             grant0, grant1;
    logic             out_hs;
    q_BASIS_poly      sel_a, sel_b;
    logic             sel_sub;
    q_BASIS_wide_poly raw_new;
    q_BASIS_poly      reduced;

    rns_modred_stage u_modred (
        .raw_i (s1_raw_q),
        .red_o (reduced)
    );

    // Arbitration looks only at the two valids and the pointer, never at
    // operand data, so a requester's ready is independent of the other's data.
    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;

        pick0  = req0_valid && (!req1_valid || !RR_EN || (rr_ptr_q == REQ0));
        pick1  = req1_valid && !pick0;

        grant0 = rst_n && s1_adv && pick0;
        grant1 = rst_n && s1_adv && pick1;

        out_hs = s2_valid_q && out_ready;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        sel_a   = grant1 ? req1_a   : req0_a;
        sel_b   = grant1 ? req1_b   : req0_b;
        sel_sub = grant1 ? req1_sub : req0_sub;
        raw_new = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            for (int unsigned j = 0; j < q_BASIS_LEN; j++) begin
                raw_new[i][j] = raw_addsub(sel_a[i][j], sel_b[i][j], sel_sub, q_BASIS[j]);
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_raw_d   = s1_raw_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        rr_ptr_d   = rr_ptr_q;
        ops_d      = ops_q + CNT_W'(out_hs);

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = reduced;
                s2_id_d   = s1_id_q;
            end
        end

        if (s1_adv) begin
            s1_valid_d = grant0 || grant1;
            if (grant0 || grant1) begin
                s1_raw_d = raw_new;
                s1_id_d  = grant1;
            end
        end

        // Pointer always moves to the requester that was not granted
        if (grant0) begin
            rr_ptr_d = REQ1;
        end else if (grant1) begin
            rr_ptr_d = REQ0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
            s1_id_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= 1'b0;
            rr_ptr_q   <= REQ0;
            ops_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_raw_q   <= s1_raw_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            rr_ptr_q   <= rr_ptr_d;
            ops_q      <= ops_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_id    = s2_id_q;
    assign ops_done  = ops_q;

endmodule

// File: tb/tb_rns_add_arbiter.sv
`timescale 1ns/1ps
module tb_rns_add_arbiter;
    import rns_add_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        r0_valid, r0_ready, r0_sub, r1_valid, r1_ready, r1_sub;
    q_BASIS_poly r0_a, r0_b, r1_a, r1_b;
    logic        out_valid, out_ready, out_id;
    q_BASIS_poly out_data;
    logic [31:0] ops_done;

    logic        f0_valid, f0_ready, f0_sub, f1_valid, f1_ready, f1_sub;
    q_BASIS_poly f0_a, f0_b, f1_a, f1_b;
    logic        f_out_valid, f_out_id;
    q_BASIS_poly f_out_data;
    logic [31:0] f_ops;

    rns_add_arbiter #(.CNT_W(32), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_a(r0_a), .req0_b(r0_b), .req0_sub(r0_sub),
        .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_a(r1_a), .req1_b(r1_b), .req1_sub(r1_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .ops_done(ops_done)
    );

    rns_add_arbiter #(.CNT_W(32), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f0_valid), .req0_ready(f0_ready), .req0_a(f0_a), .req0_b(f0_b), .req0_sub(f0_sub),
        .req1_valid(f1_valid), .req1_ready(f1_ready), .req1_a(f1_a), .req1_b(f1_b), .req1_sub(f1_sub),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data), .out_id(f_out_id),
        .ops_done(f_ops)
    );

    typedef struct {
        logic        id;
        q_BASIS_poly data;
    } exp_t;

    exp_t sb[$];
    logic glog[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   exp_ops = 0;
    int   ptr_m = 0;
    bit   prev_rst_low = 1'b1;
    bit   acc0_seen = 1'b0;
    bit   acc1_seen = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on integers
    function automatic q_BASIS_poly ref_op(input q_BASIS_poly a, input q_BASIS_poly b, input logic sub);
        q_BASIS_poly r;
        for (int i = 0; i < N_SLOTS; i++) begin
            for (int j = 0; j < q_BASIS_LEN; j++) begin
                int q, x, y;
                q = int'(q_BASIS[j]);
                x = int'(a[i][j]);
                y = int'(b[i][j]);
                r[i][j] = residue_t'(sub ? (x - y + q) % q : (x + y) % q);
            end
        end
        return r;
    endfunction

    function automatic q_BASIS_poly rand_poly();
        q_BASIS_poly r;
        for (int i = 0; i < N_SLOTS; i++)
            for (int j = 0; j < q_BASIS_LEN; j++)
                r[i][j] = residue_t'($urandom_range(32'(q_BASIS[j]) - 1));
        return r;
    endfunction

    // off < 0 means q + off in every residue, otherwise the constant off
    function automatic q_BASIS_poly const_poly(input int off);
        q_BASIS_poly r;
        for (int i = 0; i < N_SLOTS; i++)
            for (int j = 0; j < q_BASIS_LEN; j++)
                r[i][j] = residue_t'(off < 0 ? int'(q_BASIS[j]) + off : off);
        return r;
    endfunction

    // Monitor / scoreboard: the pipeline is modelled as a 2-entry in-order
    // buffer; a request is admissible when fewer than 2 results are in
    // flight or the oldest one is being handed off this cycle.
    always @(negedge clk) begin
        int   n;
        bit   can;
        int   win;
        logic e0, e1;
        cyc++;
        chk("ops_done", ops_done, exp_ops);
        if (prev_rst_low) chk("out_valid_after_reset", out_valid, 1'b0);
        n = sb.size();
        if (rst_n !== 1'b1) begin
            chk("ready0_in_reset", r0_ready, 1'b0);
            chk("ready1_in_reset", r1_ready, 1'b0);
            sb.delete();
            exp_ops = 0;
            ptr_m = 0;
            acc0_seen = 1'b0;
            acc1_seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (n == 0) begin
                    chk("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    chk("out_id", out_id, sb[0].id);
                    chk("out_data", out_data, sb[0].data);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        exp_ops++;
                    end
                end
            end
            can = (n < 2) || out_ready;
            win = -1;
            if (can && r0_valid && r1_valid) win = ptr_m;
            else if (can && r0_valid) win = 0;
            else if (can && r1_valid) win = 1;
            e0 = (win == 0);
            e1 = (win == 1);
            chk("req0_ready", r0_ready, e0);
            chk("req1_ready", r1_ready, e1);
            if (e0) sb.push_back('{id: 1'b0, data: ref_op(r0_a, r0_b, r0_sub)});
            if (e1) sb.push_back('{id: 1'b1, data: ref_op(r1_a, r1_b, r1_sub)});
            if (win >= 0) ptr_m = 1 - win;
            acc0_seen = r0_ready;
            acc1_seen = r1_ready;
            if (r0_ready) glog.push_back(1'b0);
            if (r1_ready) glog.push_back(1'b1);
            if (r0_ready || r1_ready) acc_cyc = cyc;
        end
        prev_rst_low = (rst_n !== 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycle(input int pv0, input int pv1, input int pr);
        tick();
        if (!(r0_valid && !acc0_seen)) begin
            r0_valid = (int'($urandom_range(99)) < pv0);
            r0_a = rand_poly();
            r0_b = rand_poly();
            r0_sub = 1'($urandom_range(1));
        end
        if (!(r1_valid && !acc1_seen)) begin
            r1_valid = (int'($urandom_range(99)) < pv1);
            r1_a = rand_poly();
            r1_b = rand_poly();
            r1_sub = 1'($urandom_range(1));
        end
        out_ready = (int'($urandom_range(99)) < pr);
    endtask

    task automatic drain();
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) break;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic send(input int r, input q_BASIS_poly a, input q_BASIS_poly b, input logic sub);
        bit got;
        got = 1'b0;
        tick();
        out_ready = 1'b1;
        r0_valid = (r == 0);
        r1_valid = (r == 1);
        if (r == 0) begin r0_a = a; r0_b = b; r0_sub = sub; end
        else begin r1_a = a; r1_b = b; r1_sub = sub; end
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            got = (r == 0) ? acc0_seen : acc1_seen;
        end
        chk("send_accepted", got, 1'b1);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic expect_next(input string nm, input q_BASIS_poly d, input logic id);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk({nm, "_seen"}, seen, 1'b1);
        if (seen) begin
            chk({nm, "_latency"}, cyc - acc_cyc, 2);
            chk({nm, "_data"}, out_data, d);
            chk({nm, "_id"}, out_id, id);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ops0;
        int fseen;
        q_BASIS_poly fexp;

        rst_n = 1'b0;
        out_ready = 1'b1;
        r0_valid = 1'b1; r0_a = rand_poly(); r0_b = rand_poly(); r0_sub = 1'b0;
        r1_valid = 1'b1; r1_a = rand_poly(); r1_b = rand_poly(); r1_sub = 1'b1;
        f0_valid = 1'b0; f0_a = '0; f0_b = '0; f0_sub = 1'b0;
        f1_valid = 1'b0; f1_a = '0; f1_b = '0; f1_sub = 1'b0;

        // Reset with both requesters valid, then first grant goes to req0
        repeat (2) tick();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_ops_done", ops_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("first_grant_req0", r0_ready, 1'b1);
        drain();

        // Boundary values
        send(0, const_poly(-1), const_poly(1), 1'b0);
        expect_next("add_wrap", const_poly(0), 1'b0);
        send(0, const_poly(-1), const_poly(0), 1'b0);
        expect_next("add_max", const_poly(-1), 1'b0);
        send(1, const_poly(0), const_poly(1), 1'b1);
        expect_next("sub_wrap", const_poly(-1), 1'b1);
        send(1, const_poly(5), const_poly(5), 1'b1);
        expect_next("sub_equal", const_poly(0), 1'b1);
        drain();

        // Round-robin alternation
        glog.delete();
        ops0 = int'(ops_done);
        repeat (6) rand_cycle(100, 100, 100);
        drain();
        chk("rr_grant_count", glog.size(), 6);
        for (int k = 0; k < 6 && k < glog.size(); k++) chk("rr_grant_order", glog[k], k % 2);
        chk("rr_ops_delta", int'(ops_done) - ops0, 6);

        // Backpressure: exactly two results buffered
        repeat (5) rand_cycle(100, 100, 0);
        @(negedge clk);
        #1;
        chk("bp_ready0", r0_ready, 1'b0);
        chk("bp_ready1", r1_ready, 1'b0);
        chk("bp_buffered", sb.size(), 2);
        chk("bp_out_valid", out_valid, 1'b1);
        repeat (10) rand_cycle(100, 100, 100);
        drain();

        // Random traffic
        repeat (400) rand_cycle(70, 60, 70);
        drain();

        // Fixed-priority instance: requester 0 always wins
        tick();
        out_ready = 1'b1;
        f0_a = rand_poly(); f0_b = rand_poly(); f0_sub = 1'($urandom_range(1));
        f1_a = rand_poly(); f1_b = rand_poly(); f1_sub = 1'($urandom_range(1));
        f0_valid = 1'b1;
        f1_valid = 1'b1;
        fexp = ref_op(f0_a, f0_b, f0_sub);
        fseen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (k < 6) begin
                chk("fp_ready0", f0_ready, 1'b1);
                chk("fp_ready1", f1_ready, 1'b0);
            end
            if (f_out_valid) begin
                fseen++;
                chk("fp_out_id", f_out_id, 1'b0);
                chk("fp_out_data", f_out_data, fexp);
            end
            if (k == 5) begin
                tick();
                f0_valid = 1'b0;
                f1_valid = 1'b0;
            end
        end
        chk("fp_results", fseen, 6);
        chk("fp_ops_done", f_ops, 6);

        // Reset flush with two results in flight
        drain();
        repeat (2) rand_cycle(100, 100, 100);
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_ops_done", ops_done, 0);
        @(negedge clk);
        #1;
        chk("flush_out_valid_next", out_valid, 1'b0);
        repeat (50) rand_cycle(60, 60, 80);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
